// File: rtl/division_if.sv
// Operand/result handshake bundle for the sequential divider.
// valid/ready: a transfer happens on a rising edge where both valid and ready are high; valid holds with stable payload until then.
interface division_if #(
  parameter int WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [2*WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]     divisor;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   quotient;
  logic [WIDTH-1:0]     remainder;
  logic                 div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/division.sv
// Restoring shift-subtract unsigned divider: 2*WIDTH-bit dividend by WIDTH-bit divisor,
// one quotient bit per clock, valid/ready on both sides.
module division #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  division_if.slave   bus,
  output logic [1:0]  state_o
);
  localparam int DW = 2 * WIDTH;
  localparam int CW = $clog2(DW);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [DW-1:0]    dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] pr_q, pr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]    quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   pr_shift;
  logic             fits;
  logic [WIDTH-1:0] pr_sub;

  // The compare is WIDTH+1 bits; after a restoring step the partial remainder always
  // fits in WIDTH bits (for a zero divisor only the low bits matter), so only those are stored.
  assign pr_shift = {pr_q, dvd_q[DW-1]};
  assign fits     = pr_shift >= {1'b0, dvs_q};
  assign pr_sub   = fits ? WIDTH'(pr_shift - {1'b0, dvs_q}) : pr_shift[WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    pr_d    = pr_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          dvd_d   = bus.dividend;
          dvs_d   = bus.divisor;
          pr_d    = '0;
          cnt_d   = CW'(DW - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Quotient bits enter the dividend register from the LSB as dividend bits leave the MSB.
        dvd_d = {dvd_q[DW-2:0], fits};
        pr_d  = pr_sub;
        if (cnt_q == '0) begin
          quo_d   = {dvd_q[DW-2:0], fits};
          rem_d   = pr_sub;
          dbz_d   = (dvs_q == '0);
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      pr_q    <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      pr_q    <= pr_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
  assign state_o         = state_q;
endmodule
